// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS subset over one shared memory port.
// Optional feature macro: MIPS_MC_PERF_EN adds cycle_count/instr_count.
module mips_multicycle_core #(
    parameter logic [31:0] RESET_PC     = 32'h0040_0000,
    parameter int          PORT_WIDTH   = 8,
    parameter logic [31:0] PORTIN_ADDR  = 32'hFFFF_0000,
    parameter logic [31:0] PORTOUT_ADDR = 32'hFFFF_0004
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic [31:0]           mem_rdata,
    input  logic                  mem_ready,
    input  logic [PORT_WIDTH-1:0] PortIn,
    output logic [31:0]           PortOut,
    output logic [31:0]           ALUResultOut,
    output logic                  halted
`ifdef MIPS_MC_PERF_EN
    ,
    output logic [31:0]           cycle_count,
    output logic [31:0]           instr_count
`endif
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] alu_q, alu_d;
    logic [31:0] mdr_q, mdr_d;
    logic [31:0] portout_q, portout_d;
    logic [31:0] rf_q [32];

    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [31:0] sext, zext, br_off;
    logic [31:0] alu_y;
    logic        legal;
    logic [31:0] data_addr;
    logic        hit_in, hit_out;

    assign op     = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign imm    = ir_q[15:0];
    assign sext   = {{16{imm[15]}}, imm};
    assign zext   = {16'h0000, imm};
    assign br_off = {{14{imm[15]}}, imm, 2'b00};

    assign data_addr = {alu_q[31:2], 2'b00};
    assign hit_in    = (data_addr == PORTIN_ADDR);
    assign hit_out   = (data_addr == PORTOUT_ADDR);

    assign PortOut      = portout_q;
    assign ALUResultOut = alu_q;
    assign halted       = (state_q == S_HALT);

    // Instruction legality and ALU result from the current IR and operands.
    always_comb begin
        alu_y = '0;
        legal = 1'b1;
        case (op)
            OP_R: begin
                case (funct)
                    FN_ADD:  alu_y = a_q + b_q;
                    FN_SUB:  alu_y = a_q - b_q;
                    FN_AND:  alu_y = a_q & b_q;
                    FN_OR:   alu_y = a_q | b_q;
                    FN_NOR:  alu_y = ~(a_q | b_q);
                    FN_SLL:  alu_y = b_q << shamt;
                    FN_SRL:  alu_y = b_q >> shamt;
                    default: legal = 1'b0;
                endcase
            end
            OP_J:    alu_y = '0;
            OP_BEQ,
            OP_BNE:  alu_y = a_q - b_q;
            OP_ADDI,
            OP_LW,
            OP_SW:   alu_y = a_q + sext;
            OP_ORI:  alu_y = a_q | zext;
            default: legal = 1'b0;
        endcase
    end

    // Control FSM: next state, datapath register updates and memory port.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_d     = alu_q;
        mdr_d     = mdr_q;
        portout_d = portout_q;
        rf_we     = 1'b0;
        rf_waddr  = '0;
        rf_wdata  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {pc_q[31:2], 2'b00};
        mem_wdata = b_q;
        case (state_q)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d     = rf_q[rs];
                b_d     = rf_q[rt];
                state_d = legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                alu_d = alu_y;
                case (op)
                    OP_BEQ: begin
                        if (a_q == b_q) pc_d = pc_q + br_off;
                        state_d = S_FETCH;
                    end
                    OP_BNE: begin
                        if (a_q != b_q) pc_d = pc_q + br_off;
                        state_d = S_FETCH;
                    end
                    OP_J: begin
                        pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
                        state_d = S_FETCH;
                    end
                    OP_LW,
                    OP_SW:   state_d = S_MEM;
                    default: state_d = S_WB;
                endcase
            end
            S_MEM: begin
                mem_addr = data_addr;
                if (hit_in || hit_out) begin
                    if (op == OP_LW) begin
                        mdr_d   = hit_in ? 32'(PortIn) : portout_q;
                        state_d = S_WB;
                    end else begin
                        if (hit_out) portout_d = b_q;
                        state_d = S_FETCH;
                    end
                end else begin
                    mem_req = 1'b1;
                    mem_we  = (op == OP_SW);
                    if (mem_ready) begin
                        if (op == OP_LW) begin
                            mdr_d   = mem_rdata;
                            state_d = S_WB;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_waddr = (op == OP_R) ? rd : rt;
                rf_wdata = (op == OP_LW) ? mdr_q : alu_q;
                state_d  = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
        // A pending request is dropped as soon as reset is seen.
        if (reset) begin
            mem_req = 1'b0;
            mem_we  = 1'b0;
        end
    end

    // State and datapath registers; reset wins over every write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
            mdr_q     <= '0;
            portout_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_q     <= alu_d;
            mdr_q     <= mdr_d;
            portout_q <= portout_d;
            if (rf_we && rf_waddr != 5'd0) rf_q[rf_waddr] <= rf_wdata;
        end
    end

`ifdef MIPS_MC_PERF_EN
    logic [31:0] cycle_q, cycle_d;
    logic [31:0] instr_q, instr_d;
    logic        instr_done;

    // An instruction retires on the cycle its last state hands back to FETCH.
    always_comb begin
        instr_done = (state_q == S_EXEC || state_q == S_MEM ||
                      state_q == S_WB) && (state_d == S_FETCH);
        cycle_d    = (state_q == S_HALT) ? cycle_q : cycle_q + 32'd1;
        instr_d    = instr_q + {31'd0, instr_done};
    end

    // Free-running wrap-around performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: scoreboard bench for the multicycle MIPS core.
// Programs are loaded into a behavioural memory; results checked per fetch.
module tb_mips_multicycle_core;

    localparam logic [31:0] B   = 32'h0040_0000;
    localparam logic [31:0] ILL = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  PortIn = 8'h00;
    logic [31:0] PortOut, ALUResultOut;
    logic        halted;
`ifdef MIPS_MC_PERF_EN
    logic [31:0] cycle_count, instr_count;
`endif

    logic [31:0] prog [64];
    logic [31:0] dmem [16];
    int          iwaits = 0;
    int          dwaits = 0;
    int          cur_waits;
    int          wcnt = 0;

    int errors = 0;
    int total  = 0;

    typedef struct {
        logic [31:0] alu;
        bit          chk;
        int          cyc;
        logic [31:0] npc;
        logic [31:0] pout;
    } exp_t;
    exp_t sb [$];

    mips_multicycle_core dut (
        .clk          (clk),
        .reset        (reset),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .PortIn       (PortIn),
        .PortOut      (PortOut),
        .ALUResultOut (ALUResultOut),
        .halted       (halted)
`ifdef MIPS_MC_PERF_EN
        ,
        .cycle_count  (cycle_count),
        .instr_count  (instr_count)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural memory: program at 0x0040_0000, data at 0x1001_0000.
    always_comb begin
        mem_rdata = 32'h0;
        cur_waits = iwaits;
        if (mem_addr[31:16] == 16'h0040) begin
            mem_rdata = prog[mem_addr[7:2]];
        end else if (mem_addr[31:16] == 16'h1001) begin
            mem_rdata = dmem[mem_addr[5:2]];
            cur_waits = dwaits;
        end
    end

    assign mem_ready = !mem_req || (wcnt >= cur_waits);

    always @(posedge clk) begin
        if (mem_req && !mem_ready) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    function automatic logic [31:0] ri(input int op, input int rs,
                                       input int rt, input int imm);
        return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
    endfunction

    function automatic logic [31:0] rr(input int rs, input int rt,
                                       input int rd, input int sh,
                                       input int fn);
        return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
    endfunction

    function automatic logic [31:0] jj(input logic [31:0] a);
        return {6'h02, a[27:2]};
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 64; i++) prog[i] = ILL;
        for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
        sb.delete();
    endtask

    task automatic push(input logic [31:0] alu, input bit chk, input int cyc,
                        input logic [31:0] npc, input logic [31:0] pout);
        exp_t e;
        e.alu = alu; e.chk = chk; e.cyc = cyc; e.npc = npc; e.pout = pout;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
    endtask

    // Advance to the next fetch cycle (bounded); report cycles taken,
    // any request to the port addresses, and any change while stalled.
    task automatic wait_fetch(output int cyc, output bit ok,
                              output bit preq, output bit unst);
        logic        pw, pwe;
        logic [31:0] pa, pd;
        cyc = 0; ok = 0; preq = 0; unst = 0;
        pw = mem_req && !mem_ready; pa = mem_addr; pd = mem_wdata; pwe = mem_we;
        while (cyc < 60 && !ok) begin
            @(negedge clk);
            cyc++;
            if (pw && (mem_addr !== pa || mem_we !== pwe || mem_wdata !== pd))
                unst = 1;
            if (mem_req && mem_addr[31:16] == 16'hFFFF) preq = 1;
            if (mem_req && !mem_we && mem_addr[31:16] == 16'h0040) ok = 1;
            pw = mem_req && !mem_ready; pa = mem_addr; pd = mem_wdata; pwe = mem_we;
        end
    endtask

    task automatic test_reset();
        clear_prog();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (mem_req !== 1'b0) begin errors++;
            $display("FAIL rst_mem_req: got %b want 0", mem_req); end
        total++; if (mem_we !== 1'b0) begin errors++;
            $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        total++; if (halted !== 1'b0) begin errors++;
            $display("FAIL rst_halted: got %b want 0", halted); end
        total++; if (PortOut !== 32'h0) begin errors++;
            $display("FAIL rst_portout: got %h want 0", PortOut); end
        total++; if (ALUResultOut !== 32'h0) begin errors++;
            $display("FAIL rst_alu: got %h want 0", ALUResultOut); end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        total++; if (mem_req !== 1'b1) begin errors++;
            $display("FAIL first_fetch_req: got %b want 1", mem_req); end
        total++; if (mem_addr !== B) begin errors++;
            $display("FAIL first_fetch_addr: got %h want %h", mem_addr, B); end
        total++; if (mem_we !== 1'b0) begin errors++;
            $display("FAIL first_fetch_we: got %b want 0", mem_we); end
    endtask

    task automatic test_alu();
        exp_t e; int cyc, n; bit ok, pr, un;
        clear_prog();
        prog[0] = ri(8, 0, 8, 5);
        prog[1] = ri(8, 0, 9, -3);
        prog[2] = rr(8, 9, 10, 0, 32'h20);
        prog[3] = rr(8, 0, 11, 0, 32'h27);
        push(32'h0000_0005, 1, 4, B + 32'h4, 32'h0);
        push(32'hFFFF_FFFD, 1, 4, B + 32'h8, 32'h0);
        push(32'h0000_0002, 1, 4, B + 32'hC, 32'h0);
        push(32'hFFFF_FFFA, 1, 4, B + 32'h10, 32'h0);
        do_reset();
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_fetch(cyc, ok, pr, un);
            total++; if (!ok || cyc != e.cyc) begin errors++;
                $display("FAIL alu_cycles[%0d]: got %0d want %0d", n, cyc, e.cyc); end
            total++; if (mem_addr !== e.npc) begin errors++;
                $display("FAIL alu_npc[%0d]: got %h want %h", n, mem_addr, e.npc); end
            if (e.chk) begin
                total++; if (ALUResultOut !== e.alu) begin errors++;
                    $display("FAIL alu_result[%0d]: got %h want %h", n, ALUResultOut, e.alu); end
            end
            n++;
        end
`ifdef MIPS_MC_PERF_EN
        total++; if (instr_count !== 32'd4) begin errors++;
            $display("FAIL alu_instr_count: got %0d want 4", instr_count); end
        total++; if (cycle_count !== 32'd16) begin errors++;
            $display("FAIL alu_cycle_count: got %0d want 16", cycle_count); end
`endif
    endtask

    task automatic test_load_port();
        exp_t e; int cyc, n; bit ok, pr, un;
        clear_prog();
        dmem[2] = 32'hDEAD_BEEF;
        dwaits  = 3;
        prog[0] = ri(8, 0, 8, 5);
        prog[1] = ri(13, 0, 1, 32'hFFFF);
        prog[2] = rr(0, 1, 1, 16, 0);
        prog[3] = ri(13, 0, 2, 32'h1001);
        prog[4] = rr(0, 2, 2, 16, 0);
        prog[5] = ri(32'h23, 2, 12, 8);
        prog[6] = ri(32'h2B, 1, 12, 4);
        prog[7] = ri(32'h2B, 1, 8, 4);
        push(32'h0000_0005, 1, 4, B + 32'h4, 32'h0);
        push(32'h0000_FFFF, 1, 4, B + 32'h8, 32'h0);
        push(32'hFFFF_0000, 1, 4, B + 32'hC, 32'h0);
        push(32'h0000_1001, 1, 4, B + 32'h10, 32'h0);
        push(32'h1001_0000, 1, 4, B + 32'h14, 32'h0);
        push(32'h1001_0008, 1, 8, B + 32'h18, 32'h0);
        push(32'hFFFF_0004, 1, 4, B + 32'h1C, 32'hDEAD_BEEF);
        push(32'hFFFF_0004, 1, 4, B + 32'h20, 32'h0000_0005);
        do_reset();
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_fetch(cyc, ok, pr, un);
            total++; if (!ok || cyc != e.cyc) begin errors++;
                $display("FAIL ld_cycles[%0d]: got %0d want %0d", n, cyc, e.cyc); end
            total++; if (mem_addr !== e.npc) begin errors++;
                $display("FAIL ld_npc[%0d]: got %h want %h", n, mem_addr, e.npc); end
            if (e.chk) begin
                total++; if (ALUResultOut !== e.alu) begin errors++;
                    $display("FAIL ld_result[%0d]: got %h want %h", n, ALUResultOut, e.alu); end
            end
            total++; if (PortOut !== e.pout) begin errors++;
                $display("FAIL ld_portout[%0d]: got %h want %h", n, PortOut, e.pout); end
            total++; if (pr || un) begin errors++;
                $display("FAIL ld_bus[%0d]: port_req=%b unstable=%b want 0 0", n, pr, un); end
            n++;
        end
        dwaits = 0;
    endtask

    task automatic test_branch();
        exp_t e; int cyc, n; bit ok, pr, un;
        clear_prog();
        prog[0] = ri(8, 0, 8, 1);
        prog[1] = ri(8, 9, 9, 1);
        prog[2] = ri(4, 9, 8, -2);
        prog[3] = ri(5, 9, 9, 5);
        prog[4] = jj(B + 32'h18);
        prog[6] = ri(8, 0, 10, 7);
        push(32'h0000_0001, 1, 4, B + 32'h4, 32'h0);
        push(32'h0000_0001, 1, 4, B + 32'h8, 32'h0);
        push(32'h0000_0000, 1, 3, B + 32'h4, 32'h0);
        push(32'h0000_0002, 1, 4, B + 32'h8, 32'h0);
        push(32'h0000_0001, 1, 3, B + 32'hC, 32'h0);
        push(32'h0000_0000, 1, 3, B + 32'h10, 32'h0);
        push(32'h0000_0000, 0, 3, B + 32'h18, 32'h0);
        push(32'h0000_0007, 1, 4, B + 32'h1C, 32'h0);
        do_reset();
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_fetch(cyc, ok, pr, un);
            total++; if (!ok || cyc != e.cyc) begin errors++;
                $display("FAIL br_cycles[%0d]: got %0d want %0d", n, cyc, e.cyc); end
            total++; if (mem_addr !== e.npc) begin errors++;
                $display("FAIL br_npc[%0d]: got %h want %h", n, mem_addr, e.npc); end
            if (e.chk) begin
                total++; if (ALUResultOut !== e.alu) begin errors++;
                    $display("FAIL br_result[%0d]: got %h want %h", n, ALUResultOut, e.alu); end
            end
            n++;
        end
    endtask

    task automatic test_portin_illegal();
        exp_t e; int cyc, n, bad; bit ok, pr, un;
        clear_prog();
        PortIn  = 8'hA5;
        prog[0] = ri(13, 0, 1, 32'hFFFF);
        prog[1] = rr(0, 1, 1, 16, 0);
        prog[2] = ri(32'h23, 1, 13, 0);
        prog[3] = ri(32'h2B, 1, 13, 4);
        prog[4] = ri(32'h23, 1, 14, 4);
        prog[5] = ri(8, 14, 15, 1);
        prog[6] = ri(13, 15, 15, 0);
        prog[7] = ri(32'h2B, 1, 15, 4);
        push(32'h0000_FFFF, 1, 4, B + 32'h4, 32'h0);
        push(32'hFFFF_0000, 1, 4, B + 32'h8, 32'h0);
        push(32'hFFFF_0000, 1, 5, B + 32'hC, 32'h0);
        push(32'hFFFF_0004, 1, 4, B + 32'h10, 32'h0000_00A5);
        push(32'hFFFF_0004, 1, 5, B + 32'h14, 32'h0000_00A5);
        push(32'h0000_00A6, 1, 4, B + 32'h18, 32'h0000_00A5);
        push(32'h0000_00A6, 1, 4, B + 32'h1C, 32'h0000_00A5);
        push(32'hFFFF_0004, 1, 4, B + 32'h20, 32'h0000_00A6);
        do_reset();
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            wait_fetch(cyc, ok, pr, un);
            total++; if (!ok || cyc != e.cyc) begin errors++;
                $display("FAIL pin_cycles[%0d]: got %0d want %0d", n, cyc, e.cyc); end
            if (e.chk) begin
                total++; if (ALUResultOut !== e.alu) begin errors++;
                    $display("FAIL pin_result[%0d]: got %h want %h", n, ALUResultOut, e.alu); end
            end
            total++; if (PortOut !== e.pout) begin errors++;
                $display("FAIL pin_portout[%0d]: got %h want %h", n, PortOut, e.pout); end
            n++;
        end
        @(negedge clk);
        total++; if (halted !== 1'b0) begin errors++;
            $display("FAIL halt_in_decode: got %b want 0", halted); end
        @(negedge clk);
        total++; if (halted !== 1'b1 || mem_req !== 1'b0) begin errors++;
            $display("FAIL halt_entry: halted=%b mem_req=%b want 1 0", halted, mem_req); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (halted !== 1'b1 || mem_req !== 1'b0) bad++;
        end
        total++; if (bad != 0) begin errors++;
            $display("FAIL halt_hold: got %0d bad cycles want 0", bad); end
        do_reset();
        total++; if (halted !== 1'b0 || PortOut !== 32'h0 || ALUResultOut !== 32'h0) begin
            errors++;
            $display("FAIL halt_reset: halted=%b portout=%h alu=%h want 0 0 0",
                     halted, PortOut, ALUResultOut); end
        total++; if (mem_req !== 1'b1 || mem_addr !== B) begin errors++;
            $display("FAIL halt_refetch: req=%b addr=%h want 1 %h", mem_req, mem_addr, B); end
    endtask

    task automatic test_stall_reset();
        clear_prog();
        iwaits = 1000;
        do_reset();
        repeat (3) @(negedge clk);
        total++; if (mem_req !== 1'b1 || mem_addr !== B) begin errors++;
            $display("FAIL stall_hold: req=%b addr=%h want 1 %h", mem_req, mem_addr, B); end
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (mem_req !== 1'b0) begin errors++;
            $display("FAIL stall_reset_req: got %b want 0", mem_req); end
`ifdef MIPS_MC_PERF_EN
        total++; if (cycle_count !== 32'h0 || instr_count !== 32'h0) begin errors++;
            $display("FAIL stall_reset_perf: cycles=%0d instrs=%0d want 0 0",
                     cycle_count, instr_count); end
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        iwaits = 0;
        @(negedge clk);
        total++; if (mem_req !== 1'b1 || mem_addr !== B) begin errors++;
            $display("FAIL stall_restart: req=%b addr=%h want 1 %h", mem_req, mem_addr, B); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load_port();
        test_branch();
        test_portin_illegal();
        test_stall_reset();
        $display("Result: errors=%0d of %0d checks", errors, total);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_core.md
# mips_multicycle_core

Multicycle successor to the single-cycle MIPS top level: same instruction flavour, executed by a state machine over one shared instruction/data memory port with a valid/ready handshake. The core contains the PC, IR, register file, ALU and control FSM. It also implements memory-mapped PortIn/PortOut registers; the previous generation tied PortOut to 0. The core sits between the board-level memory and the I/O pins.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset
- PORT_WIDTH, 8, width of PortIn (zero-extended on read)
- PORTIN_ADDR, 32'hFFFF_0000, word address that reads PortIn
- PORTOUT_ADDR, 32'hFFFF_0004, word address that writes the PortOut register
- clk  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high; sampled on the clk rising edge
- mem_req  out  1  memory access request; held until mem_ready
- mem_we  out  1  1 = write, 0 = read; valid while mem_req
- mem_addr  out  32  word address; bits [1:0] always driven 0
- mem_wdata  out  32  store data; valid while mem_req && mem_we
- mem_rdata  in  32  read data; sampled in the cycle mem_ready=1
- mem_ready  in  1  completes the pending access on this edge
- PortIn  in  PORT_WIDTH  external input port
- PortOut  out  32  registered output port
- ALUResultOut  out  32  registered ALU result of the last EXEC
- halted  out  1  core stopped on an illegal instruction

## Operation
- ISA:
  - R-type: add, sub, and, or, nor, sll, srl (shamt, on rt).
  - I-type: addi, ori (imm zero-extended), lw, sw, beq, bne.
  - J-type: j.
  - Any other opcode/funct is illegal and forces HALT.
- Arithmetic is 32-bit wrap-around with no overflow trap. Sign extension applies to addi, lw, sw and branch offsets.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On mem_ready: IR<=mem_rdata, PC<=PC+4, go to DECODE. Otherwise stay.
  - DECODE: A<=rf[rs], B<=rf[rt]. Illegal instruction -> HALT.
  - EXEC: ALU computes; ALUResultOut<=result.
    - beq/bne: if taken, PC<=PC+(sext(imm)<<2), where PC is already PC+4; then -> FETCH.
    - j: PC<={PC[31:28],target,2'b00}; then -> FETCH.
    - lw/sw -> MEM; all other instructions -> WB.
  - MEM: access at the ALU address.
    - PORTIN_ADDR and PORTOUT_ADDR are internal: no mem_req, complete in 1 cycle. Reading PORTOUT_ADDR returns PortOut. Writing PORTIN_ADDR is ignored.
    - Any other address: mem_req=1 until mem_ready.
    - lw -> WB; sw -> FETCH.
  - WB: rf[rd] for R-type, rf[rt] for I-type/lw, written with the ALU result or load data; then -> FETCH.
  - HALT: halted=1, mem_req=0. Exit only by reset.
- Register file: 32x32, reads are combinational, writes on the edge. $0 always reads 0; writes to it are discarded.
- sw to PORTOUT_ADDR: PortOut<=B at the end of MEM.

## Timing
- Reset values: PC=RESET_PC, state=FETCH, all registers=0, IR=0, PortOut=0, ALUResultOut=0, halted=0, mem_req=0, mem_we=0.
- With mem_ready tied high:
  - branch and j: 3 cycles.
  - R-type, addi, ori, sw: 4 cycles.
  - lw: 5 cycles.
- Each wait cycle (mem_req=1, mem_ready=0) adds exactly 1 cycle. mem_addr, mem_we and mem_wdata stay stable while waiting.
- The first mem_req is asserted in the first cycle after reset deasserts.
- Reset mid-operation has priority over everything:
  - A pending request is dropped: mem_req=0 on the cycle after the reset edge.
  - No register-file or PortOut write happens in that cycle.
- A mem_ready received when mem_req=0 is ignored.
- PC wraps modulo 2^32.

## Configuration
- MIPS_MC_PERF_EN defined:
  - Adds outputs cycle_count[31:0] and instr_count[31:0].
  - Both reset to 0 and wrap.
  - cycle_count increments every cycle not in HALT.
  - instr_count increments on each completed instruction: the last EXEC/MEM/WB cycle.
- Undefined: neither port nor either counter exists.

## Test plan
- Reset PC: reset high for 2 cycles, then low. First fetch has mem_addr=32'h0040_0000, mem_req=1, in the first cycle after reset drops.
- ALU throughput, mem_ready=1: `addi $t0,$0,5`; `addi $t1,$0,-3`; `add $t2,$t0,$t1`; `nor $t3,$t0,$0`.
  - Expect ALUResultOut 5, FFFFFFFD, 2, FFFFFFFA.
  - Each instruction takes 4 cycles.
- Loads and port output:
  - lw from an external address with 3 wait states: takes 8 cycles, with mem_addr stable throughout.
  - `sw $t0` (=5) to PORTOUT_ADDR: PortOut=5 with no mem_req during MEM.
- Branches: `beq` taken with offset -2 returns to the prior instruction, 3 cycles. `bne` with equal operands falls through to PC+4.
- Port input and illegal opcode:
  - PortIn=8'hA5 and lw from PORTIN_ADDR gives rt=32'h0000_00A5.
  - Then opcode 6'h3F: halted=1 after DECODE, mem_req stays 0, recovery only by reset.
- Reset during a stalled fetch (mem_ready=0): mem_req=0 the cycle after reset. Built with MIPS_MC_PERF_EN, both counters read 0.
